// File: rtl/marian_fpga_pkg.sv
// AXI4 bus types and encodings shared by the FPGA debug SRAM slave and its bench.
package marian_fpga_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 64;
    localparam int unsigned AXI_DATA_WIDTH = 64;
    localparam int unsigned AXI_ID_WIDTH   = 1;
    localparam int unsigned AXI_USER_WIDTH = 1;
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [5:0]                atop;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AXI_STRB_WIDTH-1:0] strb;
        logic                      last;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [1:0]                resp;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        logic         b_valid;
        axi_b_chan_t  b;
        logic         r_valid;
        axi_r_chan_t  r;
    } axi_resp_t;

endpackage

// File: rtl/fpga_axi_sram_addr_gen.sv
// Next-beat address and per-beat error flag for one AXI burst engine.
// WRAP bursts are legal only when FPGA_AXI_SRAM_WRAP_EN is defined.
module fpga_axi_sram_addr_gen
    import marian_fpga_pkg::*;
#(
    parameter int unsigned          AddrWidth = 64,
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          NumWords  = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [2:0]           i_size,
    input  logic [7:0]           i_len,
    input  logic [1:0]           i_burst,
    output logic [AddrWidth-1:0] o_next_addr_c,
    output logic                 o_err_c
);

    localparam int unsigned ByteIdxW = $clog2(DataWidth / 8);
    localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(NumWords * (DataWidth / 8));

    logic [AddrWidth-1:0] w_step;
    logic [AddrWidth-1:0] w_aligned;
    logic [AddrWidth-1:0] w_incr;
    logic [AddrWidth-1:0] w_offset;
    logic                 w_base_err;
    logic [AddrWidth-1:0] w_wrap_next;
    logic                 w_wrap_err;

    assign w_step     = AddrWidth'(1) << i_size;
    assign w_aligned  = i_addr & ~(w_step - AddrWidth'(1));
    assign w_incr     = w_aligned + w_step;
    assign w_offset   = i_addr - BaseAddr;
    assign w_base_err = (w_offset >= MemBytes) || (i_size > 3'(ByteIdxW)) || (i_burst == BURST_RSVD);

`ifdef FPGA_AXI_SRAM_WRAP_EN
    logic [AddrWidth-1:0] w_wrap_mask;
    logic                 w_len_ok;

    // Wrap window is (len+1) beats of 1<<size bytes.
    assign w_wrap_mask = ((AddrWidth'(i_len) + AddrWidth'(1)) << i_size) - AddrWidth'(1);
    assign w_len_ok    = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
    assign w_wrap_next = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
    assign w_wrap_err  = !w_len_ok || ((i_addr & (w_step - AddrWidth'(1))) != '0);
`else
    assign w_wrap_next = i_addr;
    assign w_wrap_err  = 1'b1;
`endif

    always_comb begin
        o_next_addr_c = i_addr;
        o_err_c       = w_base_err;
        case (i_burst)
            BURST_INCR: o_next_addr_c = w_incr;
            BURST_WRAP: begin
                o_next_addr_c = w_wrap_next;
                o_err_c       = w_base_err || w_wrap_err;
            end
            default: o_next_addr_c = i_addr;
        endcase
    end

endmodule

// File: rtl/fpga_axi_sram.sv
// AXI4 slave memory over a 1R1W inferred block RAM with independent read/write engines.
// Optional WRAP burst support via FPGA_AXI_SRAM_WRAP_EN (handled in fpga_axi_sram_addr_gen).
module fpga_axi_sram
    import marian_fpga_pkg::*;
#(
    parameter int unsigned          AddrWidth = 64,
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          IdWidth   = 1,
    parameter int unsigned          NumWords  = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter type                  axi_req_t  = marian_fpga_pkg::axi_req_t,
    parameter type                  axi_resp_t = marian_fpga_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  axi_req_t  axi_s_req_i,
    output axi_resp_t axi_s_resp_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned ByteIdxW  = $clog2(StrbWidth);
    localparam int unsigned IdxW      = $clog2(NumWords);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    w_state_e             r_w_state;
    logic                 r_aw_ready;
    logic                 r_w_ready;
    logic                 r_b_valid;
    logic [IdWidth-1:0]   r_b_id;
    logic [1:0]           r_b_resp;
    logic [AddrWidth-1:0] r_w_addr;
    logic [7:0]           r_w_len;
    logic [2:0]           r_w_size;
    logic [1:0]           r_w_burst;
    logic [7:0]           r_w_cnt;
    logic                 r_w_err;

    r_state_e             r_r_state;
    logic                 r_ar_ready;
    logic                 r_r_valid;
    logic [IdWidth-1:0]   r_r_id;
    logic [1:0]           r_r_resp;
    logic                 r_r_last;
    logic [AddrWidth-1:0] r_r_addr;
    logic [7:0]           r_r_len;
    logic [2:0]           r_r_size;
    logic [1:0]           r_r_burst;
    logic [7:0]           r_r_cnt;

    logic [DataWidth-1:0] r_mem [NumWords];
    logic [DataWidth-1:0] r_ram_q;

    logic [AddrWidth-1:0] w_w_next;
    logic                 w_w_err;
    logic [AddrWidth-1:0] w_r_next;
    logic                 w_r_err;
    logic                 w_w_hs;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [AddrWidth-1:0] w_wr_off;
    logic [AddrWidth-1:0] w_rd_off;
    logic [IdxW-1:0]      w_wr_idx;
    logic [IdxW-1:0]      w_rd_idx;
    logic                 w_unused;

    fpga_axi_sram_addr_gen #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .NumWords  (NumWords),
        .BaseAddr  (BaseAddr)
    ) u_w_addr_gen (
        .i_addr        (r_w_addr),
        .i_size        (r_w_size),
        .i_len         (r_w_len),
        .i_burst       (r_w_burst),
        .o_next_addr_c (w_w_next),
        .o_err_c       (w_w_err)
    );

    fpga_axi_sram_addr_gen #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .NumWords  (NumWords),
        .BaseAddr  (BaseAddr)
    ) u_r_addr_gen (
        .i_addr        (r_r_addr),
        .i_size        (r_r_size),
        .i_len         (r_r_len),
        .i_burst       (r_r_burst),
        .o_next_addr_c (w_r_next),
        .o_err_c       (w_r_err)
    );

    assign w_w_hs   = r_w_ready && axi_s_req_i.w_valid;
    assign w_wr_en  = w_w_hs && !w_w_err;
    assign w_rd_en  = (r_r_state == R_FETCH);
    assign w_wr_off = r_w_addr - BaseAddr;
    assign w_rd_off = r_r_addr - BaseAddr;
    assign w_wr_idx = w_wr_off[ByteIdxW +: IdxW];
    assign w_rd_idx = w_rd_off[ByteIdxW +: IdxW];

    // Read-before-write on the same word: the read port returns the old data.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (axi_s_req_i.w.strb[b]) begin
                    r_mem[w_wr_idx][b*8 +: 8] <= axi_s_req_i.w.data[b*8 +: 8];
                end
            end
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[w_rd_idx];
        end
    end

    // Write engine; w.last is ignored, the beat count alone ends the burst.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_w_state  <= W_IDLE;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_id     <= '0;
            r_b_resp   <= RESP_OKAY;
            r_w_addr   <= '0;
            r_w_len    <= '0;
            r_w_size   <= '0;
            r_w_burst  <= '0;
            r_w_cnt    <= '0;
            r_w_err    <= 1'b0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    r_aw_ready <= 1'b1;
                    if (r_aw_ready && axi_s_req_i.aw_valid) begin
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                        r_b_id     <= axi_s_req_i.aw.id;
                        r_w_addr   <= axi_s_req_i.aw.addr;
                        r_w_len    <= axi_s_req_i.aw.len;
                        r_w_size   <= axi_s_req_i.aw.size;
                        r_w_burst  <= axi_s_req_i.aw.burst;
                        r_w_cnt    <= '0;
                        r_w_err    <= 1'b0;
                        r_w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_w_err <= r_w_err || w_w_err;
                        if (r_w_cnt == r_w_len) begin
                            r_w_ready <= 1'b0;
                            r_b_valid <= 1'b1;
                            r_b_resp  <= (r_w_err || w_w_err) ? RESP_SLVERR : RESP_OKAY;
                            r_w_state <= W_RESP;
                        end else begin
                            r_w_cnt  <= r_w_cnt + 8'd1;
                            r_w_addr <= w_w_next;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_s_req_i.b_ready) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_w_state  <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    // Read engine: one fetch cycle then one data cycle per beat.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_r_state  <= R_IDLE;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_id     <= '0;
            r_r_resp   <= RESP_OKAY;
            r_r_last   <= 1'b0;
            r_r_addr   <= '0;
            r_r_len    <= '0;
            r_r_size   <= '0;
            r_r_burst  <= '0;
            r_r_cnt    <= '0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    r_ar_ready <= 1'b1;
                    if (r_ar_ready && axi_s_req_i.ar_valid) begin
                        r_ar_ready <= 1'b0;
                        r_r_id     <= axi_s_req_i.ar.id;
                        r_r_addr   <= axi_s_req_i.ar.addr;
                        r_r_len    <= axi_s_req_i.ar.len;
                        r_r_size   <= axi_s_req_i.ar.size;
                        r_r_burst  <= axi_s_req_i.ar.burst;
                        r_r_cnt    <= '0;
                        r_r_state  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    r_r_valid <= 1'b1;
                    r_r_resp  <= w_r_err ? RESP_SLVERR : RESP_OKAY;
                    r_r_last  <= (r_r_cnt == r_r_len);
                    r_r_state <= R_DATA;
                end
                R_DATA: begin
                    if (axi_s_req_i.r_ready) begin
                        r_r_valid <= 1'b0;
                        if (r_r_last) begin
                            r_r_last   <= 1'b0;
                            r_ar_ready <= 1'b1;
                            r_r_state  <= R_IDLE;
                        end else begin
                            r_r_cnt   <= r_r_cnt + 8'd1;
                            r_r_addr  <= w_r_next;
                            r_r_state <= R_FETCH;
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    // RAM output register is unreset; gate it so idle and error beats present zero.
    always_comb begin
        axi_s_resp_o          = '0;
        axi_s_resp_o.aw_ready = r_aw_ready;
        axi_s_resp_o.w_ready  = r_w_ready;
        axi_s_resp_o.b_valid  = r_b_valid;
        axi_s_resp_o.b.id     = r_b_id;
        axi_s_resp_o.b.resp   = r_b_resp;
        axi_s_resp_o.ar_ready = r_ar_ready;
        axi_s_resp_o.r_valid  = r_r_valid;
        axi_s_resp_o.r.id     = r_r_id;
        axi_s_resp_o.r.data   = (r_r_valid && (r_r_resp == RESP_OKAY)) ? r_ram_q : '0;
        axi_s_resp_o.r.resp   = r_r_resp;
        axi_s_resp_o.r.last   = r_r_last;
    end

    assign w_unused = ^{axi_s_req_i.aw.lock, axi_s_req_i.aw.cache, axi_s_req_i.aw.prot,
                        axi_s_req_i.aw.qos, axi_s_req_i.aw.region, axi_s_req_i.aw.atop,
                        axi_s_req_i.aw.user, axi_s_req_i.w.last, axi_s_req_i.w.user,
                        axi_s_req_i.ar.lock, axi_s_req_i.ar.cache, axi_s_req_i.ar.prot,
                        axi_s_req_i.ar.qos, axi_s_req_i.ar.region, axi_s_req_i.ar.user,
                        w_wr_off, w_rd_off};

endmodule
